// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if
//   Bundles the sequencer's control, programming and audio signals.
//   master: the controlling side (switch logic, entry writer, decdiv lookup).
//   slave : the tone_sequencer itself.
//
//   Signals
//     wr_en/wr_addr/wr_note/wr_dur/wr_rest : program one sequence entry
//     start/stop/loop_en                   : playback control
//     count_in                             : half-period from decdiv(note_idx)
//     note_idx/tone/busy/done/step         : sequencer outputs
//
//   Handshake: there is no valid/ready pair. wr_en qualifies the wr_* fields
//   for exactly the cycle it is high; start and stop are sampled every clock
//   edge; done is a one-cycle pulse; busy is a level.
interface tone_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_note;
  logic [7:0]    wr_dur;
  logic          wr_rest;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [16:0]   count_in;
  logic [3:0]    note_idx;
  logic          tone;
  logic          busy;
  logic          done;
  logic [AW-1:0] step;

  modport master (
    output wr_en, wr_addr, wr_note, wr_dur, wr_rest,
    output start, stop, loop_en, count_in,
    input  note_idx, tone, busy, done, step
  );

  modport slave (
    input  wr_en, wr_addr, wr_note, wr_dur, wr_rest,
    input  start, stop, loop_en, count_in,
    output note_idx, tone, busy, done, step
  );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a programmable melody of up to DEPTH steps as a square wave.
//   Each entry holds a note index, a duration in ticks (0 = end marker) and a
//   rest flag. Each step is followed by GAP_TICKS silent ticks. Playback is
//   single shot or looped (loop_en).
//
//   Ports
//     clk, rst     : clock, asynchronous active-high reset
//     bus (slave)  : programming, control, decdiv lookup and audio outputs
//     state_dbg_o  : current FSM state (0 IDLE, 1 LOAD, 2 PLAY, 3 GAP)
module tone_sequencer #(
  parameter int DEPTH     = 8,
  parameter int TICK_DIV  = 27000,
  parameter int GAP_TICKS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  tone_sequencer_if.slave      bus,
  output logic [1:0]           state_dbg_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PLAY = 2'd2, S_GAP = 2'd3} state_t;

  // Sequence memory
  logic [3:0] note_mem_q [DEPTH];
  logic [7:0] dur_mem_q  [DEPTH];
  logic       rest_mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [3:0]    note_q, note_d;
  logic [7:0]    dur_cnt_q, dur_cnt_d;
  logic          rest_q, rest_d;
  logic [16:0]   hp_q, hp_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tone_q, tone_d;
  logic          done_q, done_d;
  logic [AW-1:0] step_q, step_d;

  logic          tick;
  logic          advance;
  logic          end_seq;
  logic [16:0]   hp_lim;

  // Writes land at the clock edge in any state; LOAD reads the registered copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        note_mem_q[i] <= '0;
        dur_mem_q[i]  <= '0;
        rest_mem_q[i] <= 1'b0;
      end
    end else if (bus.wr_en) begin
      note_mem_q[bus.wr_addr] <= bus.wr_note;
      dur_mem_q[bus.wr_addr]  <= bus.wr_dur;
      rest_mem_q[bus.wr_addr] <= bus.wr_rest;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      note_q    <= '0;
      dur_cnt_q <= '0;
      rest_q    <= 1'b0;
      hp_q      <= '0;
      pre_q     <= '0;
      gap_q     <= '0;
      tone_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      note_q    <= note_d;
      dur_cnt_q <= dur_cnt_d;
      rest_q    <= rest_d;
      hp_q      <= hp_d;
      pre_q     <= pre_d;
      gap_q     <= gap_d;
      tone_q    <= tone_d;
      done_q    <= done_d;
      step_q    <= step_d;
    end
  end

  // Half-periods below 2 cycles are clamped so the toggle rate stays defined.
  assign hp_lim = (bus.count_in < 17'd2) ? 17'd2 : bus.count_in;
  assign tick   = (pre_q == PW'(TICK_DIV - 1));

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    note_d    = note_q;
    dur_cnt_d = dur_cnt_q;
    rest_d    = rest_q;
    hp_d      = hp_q;
    pre_d     = pre_q;
    gap_d     = gap_q;
    tone_d    = tone_q;
    done_d    = 1'b0;
    step_d    = step_q;
    advance   = 1'b0;
    end_seq   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (bus.start && !bus.stop) begin
          ptr_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        note_d    = note_mem_q[ptr_q];
        dur_cnt_d = dur_mem_q[ptr_q];
        rest_d    = rest_mem_q[ptr_q];
        step_d    = ptr_q;
        if (dur_mem_q[ptr_q] == 8'd0) begin
          end_seq = 1'b1;
        end else begin
          state_d = S_PLAY;
          pre_d   = '0;
          hp_d    = '0;
          tone_d  = 1'b0;
        end
      end
      S_PLAY: begin
        if (hp_q == hp_lim - 17'd1) begin
          hp_d   = '0;
          tone_d = rest_q ? 1'b0 : ~tone_q;
        end else begin
          hp_d = hp_q + 17'd1;
        end
        if (tick) begin
          pre_d     = '0;
          dur_cnt_d = dur_cnt_q - 8'd1;
          // Leaving on the tick that empties dur_cnt gives dur*TICK_DIV cycles.
          if (dur_cnt_q == 8'd1) begin
            tone_d = 1'b0;
            if (GAP_TICKS > 0) begin
              state_d = S_GAP;
              gap_d   = GW'(GAP_TICKS);
            end else begin
              advance = 1'b1;
            end
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_GAP: begin
        tone_d = 1'b0;
        if (tick) begin
          pre_d = '0;
          gap_d = gap_q - GW'(1);
          if (gap_q == GW'(1)) advance = 1'b1;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (ptr_q == AW'(DEPTH - 1)) begin
        end_seq = 1'b1;
      end else begin
        ptr_d   = ptr_q + AW'(1);
        state_d = S_LOAD;
      end
    end

    if (end_seq) begin
      if (bus.loop_en) begin
        ptr_d   = '0;
        state_d = S_LOAD;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // stop overrides every other transition.
    if (bus.stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    bus.note_idx = note_q;
    bus.tone     = tone_q;
    bus.busy     = (state_q != S_IDLE);
    bus.done     = done_q;
    bus.step     = step_q;
    state_dbg_o  = state_q;
  end
endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;
  localparam int DEPTH     = 4;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
  localparam int AW        = 2;
  localparam logic [1:0] ST_PLAY = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int checks = 0;
  int errors = 0;

  tone_sequencer_if #(.DEPTH(DEPTH)) bus();

  tone_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // decdiv model
  assign bus.count_in = 17'(bus.note_idx) + 17'd2;

  typedef struct {
    logic [3:0] note;
    logic [7:0] dur;
    logic       rest;
    int         exp_busy;
    int         exp_high;
    int         exp_note_done;
  } vec_t;

  vec_t vecs[6];
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic write_entry(input int addr, input int note, input int dur, input logic rest);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_note = 4'(note);
    bus.wr_dur  = 8'(dur);
    bus.wr_rest = rest;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Pulses start and follows the run until busy drops (bounded).
  task automatic run_play(output int busy_n, output int high_n, output int done_n,
                          output int note_at, output int note_done,
                          output int done_busy, output int timeout);
    busy_n = 0; high_n = 0; done_n = 0; note_at = -1; note_done = -1;
    done_busy = 0; timeout = 1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.busy) busy_n++;
      if (bus.tone) high_n++;
      if (bus.busy && busy_n == 2) note_at = int'(bus.note_idx);
      if (bus.done) begin
        done_n++;
        note_done = int'(bus.note_idx);
        if (bus.busy) done_busy = 1;
      end
      if (!bus.busy) begin
        timeout = 0;
        break;
      end
      @(negedge clk);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
  endtask

  initial begin
    int busy_n, high_n, done_n, note_at, note_done, done_busy, timeout;
    int cnt, bad;
    logic [1:0] prev_state;

    vecs[0] = '{note: 4'd1, dur: 8'd2, rest: 1'b0, exp_busy: 14, exp_high: 3, exp_note_done: 15};
    vecs[1] = '{note: 4'd0, dur: 8'd1, rest: 1'b0, exp_busy: 10, exp_high: 2, exp_note_done: 15};
    vecs[2] = '{note: 4'd3, dur: 8'd3, rest: 1'b0, exp_busy: 18, exp_high: 5, exp_note_done: 15};
    vecs[3] = '{note: 4'd2, dur: 8'd2, rest: 1'b1, exp_busy: 14, exp_high: 0, exp_note_done: 15};
    vecs[4] = '{note: 4'd4, dur: 8'd3, rest: 1'b0, exp_busy: 18, exp_high: 6, exp_note_done: 15};
    vecs[5] = '{note: 4'd9, dur: 8'd0, rest: 1'b0, exp_busy: 1,  exp_high: 0, exp_note_done: 9};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_note = '0; bus.wr_dur = '0; bus.wr_rest = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_tone", int'(bus.tone), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_note", int'(bus.note_idx), 0);
    check("reset_step", int'(bus.step), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_state", int'(state_dbg), 0);

    // Table-driven single-step melodies
    write_entry(1, 15, 0, 1'b0);
    for (int v = 0; v < 6; v++) begin
      write_entry(0, int'(vecs[v].note), int'(vecs[v].dur), vecs[v].rest);
      run_play(busy_n, high_n, done_n, note_at, note_done, done_busy, timeout);
      check($sformatf("v%0d_timeout", v), timeout, 0);
      check($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_busy);
      check($sformatf("v%0d_tone_high", v), high_n, vecs[v].exp_high);
      check($sformatf("v%0d_done_pulses", v), done_n, 1);
      check($sformatf("v%0d_busy_at_done", v), done_busy, 0);
      check($sformatf("v%0d_note_at_done", v), note_done, vecs[v].exp_note_done);
      if (vecs[v].dur != 8'd0)
        check($sformatf("v%0d_note_in_play", v), note_at, int'(vecs[v].note));
    end

    // Tone waveform of the basic step, cycle by cycle
    write_entry(0, 1, 2, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      check($sformatf("shape_tone_c%0d", n), int'(bus.tone), (n >= 5 && n <= 7) ? 1 : 0);
      check($sformatf("shape_busy_c%0d", n), int'(bus.busy), 1);
      @(negedge clk);
    end
    check("shape_done", int'(bus.done), 1);
    check("shape_busy_end", int'(bus.busy), 0);

    // Full table, no loop
    for (int a = 0; a < 4; a++) write_entry(a, a + 1, 1, 1'b0);
    for (int a = 0; a < 4; a++) exp_q.push_back(AW'(a));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0; timeout = 1; prev_state = 2'd0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) begin
        timeout = 0;
        break;
      end
      cnt++;
      if (state_dbg == ST_PLAY && prev_state != ST_PLAY) begin
        if (exp_q.size() == 0) check("full_extra_step", int'(bus.step), -1);
        else check("full_step", int'(bus.step), int'(exp_q.pop_front()));
      end
      prev_state = state_dbg;
      @(negedge clk);
    end
    check("full_timeout", timeout, 0);
    check("full_busy_cycles", cnt, 36);
    check("full_done_at_fall", int'(bus.done), 1);
    check("full_steps_left", exp_q.size(), 0);
    exp_q.delete();

    // Rest and loop
    write_entry(0, 2, 1, 1'b1);
    write_entry(1, 5, 0, 1'b0);
    bus.loop_en = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    high_n = 0; done_n = 0; busy_n = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.tone) high_n++;
      if (bus.done) done_n++;
      if (bus.busy) busy_n++;
      if (state_dbg == ST_PLAY && bus.step != '0) bad++;
      @(negedge clk);
    end
    check("loop_tone_high", high_n, 0);
    check("loop_done", done_n, 0);
    check("loop_busy", busy_n, 60);
    check("loop_step_nonzero", bad, 0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    check("loop_stop_busy", int'(bus.busy), 0);
    check("loop_stop_done", int'(bus.done), 0);

    // Stop mid-PLAY
    write_entry(0, 1, 2, 1'b0);
    write_entry(1, 15, 0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("stop_pre_tone", int'(bus.tone), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_busy", int'(bus.busy), 0);
    check("stop_tone", int'(bus.tone), 0);
    done_n = int'(bus.done);
    repeat (3) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("stop_no_done", done_n, 0);
    run_play(busy_n, high_n, done_n, note_at, note_done, done_busy, timeout);
    check("restart_busy", busy_n, 14);
    check("restart_note", note_at, 1);
    check("restart_done", done_n, 1);

    // Write to the playing entry
    write_entry(1, 1, 0, 1'b0);
    bus.loop_en = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) begin
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_note = 4'd6; bus.wr_dur = 8'd2; bus.wr_rest = 1'b0;
      end else begin
        bus.wr_en = 1'b0;
      end
      if (n == 8)  check("wr_old_note_play", int'(bus.note_idx), 1);
      if (n == 15) check("wr_old_note_reload", int'(bus.note_idx), 1);
      if (n == 16) check("wr_new_note", int'(bus.note_idx), 6);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    check("wr_stop_busy", int'(bus.busy), 0);

    // start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("startstop_busy", int'(bus.busy), 0);
    check("startstop_state", int'(state_dbg), 0);
    @(negedge clk);
    check("startstop_busy_later", int'(bus.busy), 0);

    // Asynchronous reset mid-PLAY
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("arst_pre_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_tone", int'(bus.tone), 0);
    check("arst_note", int'(bus.note_idx), 0);
    check("arst_step", int'(bus.step), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_play(busy_n, high_n, done_n, note_at, note_done, done_busy, timeout);
    check("arst_empty_timeout", timeout, 0);
    check("arst_empty_busy", busy_n, 1);
    check("arst_empty_done", done_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
